// File: rtl/uart_autobaud_pkg.sv
// Shared UART definitions: autobaud FSM encoding, config word layout and parity codes.
package uart_autobaud_pkg;

    // Autobaud detector states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FALL = 3'd1,
        ST_MEASURE   = 3'd2,
        ST_WAIT_STOP = 3'd3,
        ST_OUTPUT    = 3'd4
    } state_t;

    // Config word layout: {stop, byte_size, parity, prescaler}
    localparam int CFG_W      = 24;
    localparam int PRESC_LSB  = 0;
    localparam int PRESC_W    = 16;
    localparam int PARITY_LSB = 16;
    localparam int PARITY_W   = 3;
    localparam int BSIZE_LSB  = 19;
    localparam int BSIZE_W    = 4;
    localparam int STOP_BIT   = 23;

    // Parity codes carried in the config word
    localparam logic [PARITY_W-1:0] PARITY_NONE  = 3'd0;
    localparam logic [PARITY_W-1:0] PARITY_EVEN  = 3'd1;
    localparam logic [PARITY_W-1:0] PARITY_ODD   = 3'd2;
    localparam logic [PARITY_W-1:0] PARITY_MARK  = 3'd3;
    localparam logic [PARITY_W-1:0] PARITY_SPACE = 3'd4;

    // Assemble a config word from its fields
    function automatic logic [CFG_W-1:0] pack_config(
        input logic                stop,
        input logic [BSIZE_W-1:0]  bsize,
        input logic [PARITY_W-1:0] parity,
        input logic [PRESC_W-1:0]  presc
    );
        logic [CFG_W-1:0] cfg;
        cfg                             = '0;
        cfg[STOP_BIT]                   = stop;
        cfg[BSIZE_LSB +: BSIZE_W]       = bsize;
        cfg[PARITY_LSB +: PARITY_W]     = parity;
        cfg[PRESC_LSB +: PRESC_W]       = presc;
        return cfg;
    endfunction

endpackage

// File: rtl/uart_autobaud_if.sv
// AXI-Stream style config channel produced by the autobaud detector.
interface uart_autobaud_if;
    import uart_autobaud_pkg::*;

    logic [CFG_W-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for the asynchronous rx line with rise/fall pulses.
module uart_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize rx and keep one older sample for edge detection; idle line is high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_sync = r_sync;
    assign o_rise    = r_sync & ~r_prev;
    assign o_fall    = ~r_sync & r_prev;

endmodule

// File: rtl/uart_autobaud.sv
// Measures a 0x55 sync character on rx and emits the matching UART config word.
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int PARITY        = 0,
    parameter int BYTE_SIZE     = 8,
    parameter int STOP_BITS     = 0,
    parameter int MIN_PRESCALER = 16,
    parameter int CNT_WIDTH     = 19
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            enable,
    input  logic            rx,
    uart_autobaud_if.master m_axis_config,
    output logic            locked,
    output logic            error
);

    // One extra bit so the prescaler range check sees values above 16 bits
    localparam int PW = CNT_WIDTH + 1;

    localparam logic [PARITY_W-1:0] CFG_PARITY = PARITY[PARITY_W-1:0];
    localparam logic [BSIZE_W-1:0]  CFG_BSIZE  = BYTE_SIZE[BSIZE_W-1:0];
    localparam logic                CFG_STOP   = STOP_BITS[0];

    state_t r_state;
    state_t w_state_next;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_ivl;
    logic [CNT_WIDTH-1:0] r_i0;
    logic [2:0]           r_edges;
    logic [PRESC_W-1:0]   r_presc;
    logic [CFG_W-1:0]     r_tdata;
    logic                 r_tvalid;
    logic                 r_locked;
    logic                 r_error;

    logic w_rx_sync;
    logic w_rise;
    logic w_fall;

    logic [CNT_WIDTH-1:0] w_ivl_now;
    logic [CNT_WIDTH-1:0] w_diff;
    logic                 w_ivl_ok;
    logic [PW-1:0]        w_total;
    logic [PW-1:0]        w_p_full;
    logic                 w_p_ok;
    logic [PW-1:0]        w_two_p;
    logic                 w_cnt_ovf;
    logic                 w_counting;

    logic w_err;
    logic w_start;
    logic w_fall_ok;
    logic w_latch_i0;
    logic w_latch_p;
    logic w_load_out;
    logic w_accept;

    uart_sync_edge u_sync (
        .i_clk     (aclk),
        .i_rst     (areset),
        .i_rx      (rx),
        .o_rx_sync (w_rx_sync),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    // Cycles elapsed counts include the current one, so intervals and T come out exact
    assign w_ivl_now  = r_ivl + 1'b1;
    assign w_diff     = (w_ivl_now > r_i0) ? (w_ivl_now - r_i0) : (r_i0 - w_ivl_now);
    assign w_ivl_ok   = (w_diff <= (r_i0 >> 2));
    assign w_total    = {1'b0, r_cnt} + PW'(1);
    assign w_p_full   = (w_total + PW'(4)) >> 3;
    assign w_p_ok     = (w_p_full >= PW'(MIN_PRESCALER)) && (w_p_full <= PW'(65535));
    assign w_two_p    = PW'({r_presc, 1'b0});
    assign w_cnt_ovf  = &r_cnt;
    assign w_counting = (r_state == ST_MEASURE) || (r_state == ST_WAIT_STOP);

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_start      = 1'b0;
        w_fall_ok    = 1'b0;
        w_latch_i0   = 1'b0;
        w_latch_p    = 1'b0;
        w_load_out   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_rx_sync) begin
                    w_state_next = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_fall) begin
                    w_start      = 1'b1;
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_cnt_ovf) begin
                    w_err        = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_fall) begin
                    if (r_edges == 3'd1) begin
                        // Second fall: first interval becomes the reference
                        w_latch_i0 = 1'b1;
                        w_fall_ok  = 1'b1;
                    end else if (!w_ivl_ok) begin
                        w_err        = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (r_edges == 3'd4) begin
                        // Fifth fall closes the 0x55 measurement window
                        if (w_p_ok) begin
                            w_fall_ok    = 1'b1;
                            w_latch_p    = 1'b1;
                            w_state_next = ST_WAIT_STOP;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_fall_ok = 1'b1;
                    end
                end
            end
            ST_WAIT_STOP: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_cnt_ovf) begin
                    w_err        = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_rise) begin
                    w_load_out   = 1'b1;
                    w_state_next = ST_OUTPUT;
                end else if (PW'(w_ivl_now) > w_two_p) begin
                    w_err        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_OUTPUT: begin
                // Enable and rx are ignored until the word is taken
                if (m_axis_config.tready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Measurement counters, latched results and output registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt    <= '0;
            r_ivl    <= '0;
            r_i0     <= '0;
            r_edges  <= '0;
            r_presc  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_locked <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_error <= w_err;
            if (w_start) begin
                r_cnt   <= '0;
                r_ivl   <= '0;
                r_edges <= 3'd1;
            end else begin
                if (w_counting) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_fall_ok) begin
                    r_ivl   <= '0;
                    r_edges <= r_edges + 3'd1;
                end else if (w_counting) begin
                    r_ivl <= r_ivl + 1'b1;
                end
            end
            if (w_latch_i0) begin
                r_i0 <= w_ivl_now;
            end
            if (w_latch_p) begin
                r_presc <= w_p_full[PRESC_W-1:0];
            end
            if (w_load_out) begin
                r_tdata  <= pack_config(CFG_STOP, CFG_BSIZE, CFG_PARITY, r_presc);
                r_tvalid <= 1'b1;
            end else if (w_accept) begin
                r_tvalid <= 1'b0;
                r_locked <= 1'b1;
            end
        end
    end

    assign m_axis_config.tdata  = r_tdata;
    assign m_axis_config.tvalid = r_tvalid;
    assign locked               = r_locked;
    assign error                = r_error;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: sync-character frames with a config-word scoreboard.
module tb_uart_autobaud;

    logic aclk = 1'b0;
    logic areset;
    logic enable;
    logic rx;
    logic locked;
    logic error;

    uart_autobaud_if cfg_if ();

    uart_autobaud dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .rx            (rx),
        .m_axis_config (cfg_if),
        .locked        (locked),
        .error         (error)
    );

    always #5 aclk = ~aclk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_err_pulses = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    // Observe error pulses and accepted config beats away from the active edge
    always @(negedge aclk) begin
        if (error === 1'b1) n_err_pulses++;
        if (cfg_if.tvalid === 1'b1 && cfg_if.tready === 1'b1) obs_q.push_back(cfg_if.tdata);
    end

    // Absolute time limit
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) step();
        areset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        repeat (5) step();
    endtask

    task automatic send_frame(input logic [7:0] b, input int bt);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (bt) step();
        end
        repeat (40) step();
    endtask

    task automatic send_partial(input logic [7:0] b, input int bt, input int nbits, input int extra);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (bt) step();
        end
        rx = bits[nbits];
        repeat (extra) step();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        enable = 1'b1;
        rx = 1'b1;
        cfg_if.tready = 1'b1;
        repeat (3) step();
        areset = 1'b0;
        step();
        n_assert++;
        if (cfg_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b want=0", cfg_if.tvalid); end
        n_assert++;
        if (cfg_if.tdata !== 24'h0) begin n_fail++; $display("FAIL reset_tdata got=%h want=000000", cfg_if.tdata); end
        n_assert++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b want=0", locked); end
        n_assert++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b want=0", error); end
    endtask

    task automatic test_lock_1085();
        int e0;
        logic [23:0] got, want;
        do_reset();
        cfg_if.tready = 1'b1;
        e0 = n_err_pulses;
        exp_q.push_back(24'h40043D);
        send_frame(8'h55, 1085);
        n_assert++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL lock1085_beats got=%0d want=1", obs_q.size()); end
        got  = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
        want = exp_q.pop_front();
        n_assert++;
        if (got !== want) begin n_fail++; $display("FAIL lock1085_tdata got=%h want=%h", got, want); end
        n_assert++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock1085_locked got=%b want=1", locked); end
        n_assert++;
        if (n_err_pulses - e0 != 0) begin n_fail++; $display("FAIL lock1085_error got=%0d want=0", n_err_pulses - e0); end
        obs_q.delete();
    endtask

    task automatic test_backpressure_868();
        int e0;
        logic [23:0] got, want;
        do_reset();
        cfg_if.tready = 1'b0;
        e0 = n_err_pulses;
        exp_q.push_back(24'h400364);
        send_frame(8'h55, 868);
        n_assert++;
        if (cfg_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid_up got=%b want=1", cfg_if.tvalid); end
        for (int c = 0; c < 20; c++) begin
            // Line activity while the word is pending must not disturb it
            if (c == 5) rx = 1'b0;
            if (c == 10) rx = 1'b1;
            step();
            n_assert++;
            if (cfg_if.tdata !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold_tdata cyc=%0d got=%h want=%h", c, cfg_if.tdata, exp_q[0]); end
            n_assert++;
            if (cfg_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_tvalid cyc=%0d got=%b want=1", c, cfg_if.tvalid); end
        end
        n_assert++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_early_beat got=%0d want=0", obs_q.size()); end
        cfg_if.tready = 1'b1;
        step();
        step();
        got  = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
        want = exp_q.pop_front();
        n_assert++;
        if (got !== want) begin n_fail++; $display("FAIL bp_tdata got=%h want=%h", got, want); end
        n_assert++;
        if (cfg_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_tvalid_down got=%b want=0", cfg_if.tvalid); end
        n_assert++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL bp_locked got=%b want=1", locked); end
        n_assert++;
        if (n_err_pulses - e0 != 0) begin n_fail++; $display("FAIL bp_error got=%0d want=0", n_err_pulses - e0); end
        obs_q.delete();
    endtask

    task automatic test_bad_interval();
        int e0;
        do_reset();
        cfg_if.tready = 1'b1;
        e0 = n_err_pulses;
        send_frame(8'h5D, 1085);
        n_assert++;
        if (n_err_pulses - e0 != 1) begin n_fail++; $display("FAIL badivl_error got=%0d want=1", n_err_pulses - e0); end
        n_assert++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL badivl_beats got=%0d want=0", obs_q.size()); end
        n_assert++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL badivl_locked got=%b want=0", locked); end
    endtask

    task automatic test_small_prescaler();
        int e0;
        do_reset();
        cfg_if.tready = 1'b1;
        e0 = n_err_pulses;
        send_frame(8'h55, 10);
        n_assert++;
        if (n_err_pulses - e0 != 1) begin n_fail++; $display("FAIL smallp_error got=%0d want=1", n_err_pulses - e0); end
        n_assert++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL smallp_beats got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        logic [23:0] got, want;
        do_reset();
        cfg_if.tready = 1'b1;
        e0 = n_err_pulses;
        send_partial(8'h55, 434, 4, 217);
        areset = 1'b1;
        rx = 1'b1;
        repeat (3) step();
        n_assert++;
        if (cfg_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid got=%b want=0", cfg_if.tvalid); end
        areset = 1'b0;
        repeat (20) step();
        n_assert++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_first_frame_beats got=%0d want=0", obs_q.size()); end
        exp_q.push_back(24'h4001B2);
        send_frame(8'h55, 434);
        n_assert++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL midrst_beats got=%0d want=1", obs_q.size()); end
        got  = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
        want = exp_q.pop_front();
        n_assert++;
        if (got !== want) begin n_fail++; $display("FAIL midrst_tdata got=%h want=%h", got, want); end
        n_assert++;
        if (n_err_pulses - e0 != 0) begin n_fail++; $display("FAIL midrst_error got=%0d want=0", n_err_pulses - e0); end
        obs_q.delete();
    endtask

    task automatic test_enable_abort();
        int e0;
        logic [23:0] got, want;
        do_reset();
        cfg_if.tready = 1'b1;
        e0 = n_err_pulses;
        send_partial(8'h55, 1085, 2, 500);
        enable = 1'b0;
        rx = 1'b1;
        repeat (50) step();
        n_assert++;
        if (n_err_pulses - e0 != 0) begin n_fail++; $display("FAIL abort_error got=%0d want=0", n_err_pulses - e0); end
        n_assert++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_beats got=%0d want=0", obs_q.size()); end
        n_assert++;
        if (cfg_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL abort_tvalid got=%b want=0", cfg_if.tvalid); end
        enable = 1'b1;
        repeat (20) step();
        exp_q.push_back(24'h40043D);
        send_frame(8'h55, 1085);
        got  = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
        want = exp_q.pop_front();
        n_assert++;
        if (got !== want) begin n_fail++; $display("FAIL reenable_tdata got=%h want=%h", got, want); end
        n_assert++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL reenable_locked got=%b want=1", locked); end
        obs_q.delete();
    endtask

    task automatic test_locked_sticky();
        int e0;
        e0 = n_err_pulses;
        send_frame(8'h5D, 1085);
        n_assert++;
        if (n_err_pulses - e0 != 1) begin n_fail++; $display("FAIL sticky_error got=%0d want=1", n_err_pulses - e0); end
        n_assert++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL sticky_locked got=%b want=1", locked); end
        n_assert++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL sticky_beats got=%0d want=0", obs_q.size()); end
        do_reset();
        n_assert++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL sticky_reset_locked got=%b want=0", locked); end
    endtask

    initial begin
        areset = 1'b1;
        enable = 1'b1;
        rx = 1'b1;
        cfg_if.tready = 1'b1;
        test_reset();
        test_lock_1085();
        test_backpressure_868();
        test_bad_interval();
        test_small_prescaler();
        test_reset_mid_frame();
        test_enable_abort();
        test_locked_sticky();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
